// File: rtl/ssp_pkg.sv
// Shared constants and types for the SSP revision/ID register slice.
package ssp_pkg;

    // Word addresses (byte offset >> 2) of the PrimeCell ID registers
    localparam logic [9:0] SSP_PERIPHID0 = 10'h3F8;
    localparam logic [9:0] SSP_PERIPHID1 = 10'h3F9;
    localparam logic [9:0] SSP_PERIPHID2 = 10'h3FA;
    localparam logic [9:0] SSP_PERIPHID3 = 10'h3FB;
    localparam logic [9:0] SSP_PCELLID0  = 10'h3FC;
    localparam logic [9:0] SSP_PCELLID1  = 10'h3FD;
    localparam logic [9:0] SSP_PCELLID2  = 10'h3FE;
    localparam logic [9:0] SSP_PCELLID3  = 10'h3FF;

    localparam logic [7:0] SSP_PCELLID0_VAL = 8'h0D;
    localparam logic [7:0] SSP_PCELLID1_VAL = 8'hF0;
    localparam logic [7:0] SSP_PCELLID2_VAL = 8'h05;
    localparam logic [7:0] SSP_PCELLID3_VAL = 8'hB1;

    typedef enum logic {
        SETTLE = 1'b0,
        LOCK   = 1'b1
    } revState_t;

    // The ID window is the top eight words of the 4 KB peripheral space
    function automatic logic isIdAddr(input logic [9:0] addr);
        return addr >= SSP_PERIPHID0;
    endfunction

endpackage

// File: rtl/ssp_rev_id_regs_if.sv
// APB read-path signals between the SSP address decoder and the ID register block.
interface ssp_rev_id_regs_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [9:0]  PADDR;
    logic [31:0] PRDATA;
    logic        IdSel;

    modport master (output PSEL, PENABLE, PWRITE, PADDR, input PRDATA, IdSel);
    modport slave  (input PSEL, PENABLE, PWRITE, PADDR, output PRDATA, IdSel);
endinterface

// File: rtl/ssp_strap_sync.sv
// Tie-off strap AND, two-flop synchroniser and stability counter.
module ssp_strap_sync #(
    parameter int REV_WIDTH     = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic [REV_WIDTH-1:0] TieOff1,
    input  logic [REV_WIDTH-1:0] TieOff2,
    input  logic                 Clear,
    output logic [REV_WIDTH-1:0] Sync,
    output logic                 Stable
);

    logic [REV_WIDTH-1:0] raw;
    logic [REV_WIDTH-1:0] meta;
    logic [REV_WIDTH-1:0] syncQ;
    logic [7:0]           count;
    logic                 change;

    assign raw = TieOff1 & TieOff2;
    // Compare against the value about to enter Sync so the window starts the
    // cycle a new value lands, giving a lock latency of 2 + SETTLE_CYCLES.
    assign change = (meta != syncQ);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            meta  <= '0;
            syncQ <= '0;
            count <= '0;
        end else begin
            meta  <= raw;
            syncQ <= meta;
            if (Clear || change)
                count <= '0;
            else if (count != 8'hFF)
                count <= count + 8'd1;
        end
    end

    assign Sync   = syncQ;
    assign Stable = !change && (count == 8'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/ssp_rev_id_regs.sv
// Strap-derived revision lock plus the PrimeCell peripheral/cell ID read path.
//   state  | meaning
//   SETTLE | waiting for the synchronised straps to hold steady
//   LOCK   | Revision captured and reported valid
module ssp_rev_id_regs
    import ssp_pkg::*;
#(
    parameter int          REV_WIDTH     = 4,
    parameter logic [11:0] PART_NUM      = 12'h022,
    parameter logic [7:0]  DESIGNER      = 8'h41,
    parameter logic [7:0]  CONFIG        = 8'h00,
    parameter int          SETTLE_CYCLES = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    ssp_rev_id_regs_if.slave      apb,
    input  logic [REV_WIDTH-1:0]  TieOff1,
    input  logic [REV_WIDTH-1:0]  TieOff2,
    input  logic                  ReSample,
    output logic [REV_WIDTH-1:0]  Revision,
    output logic                  RevisionValid
);

    revState_t            state, nextState;
    logic [REV_WIDTH-1:0] sync;
    logic                 stable;
    logic                 loadRev;
    logic [3:0]           revField;
    logic [7:0]           rdNext;
    logic [7:0]           rdByte;
    logic                 idSelQ;
    logic                 setup;

    ssp_strap_sync #(
        .REV_WIDTH     (REV_WIDTH),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_strap_sync (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .TieOff1 (TieOff1),
        .TieOff2 (TieOff2),
        .Clear   (ReSample),
        .Sync    (sync),
        .Stable  (stable)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            state <= SETTLE;
        else
            state <= nextState;
    end

    // ReSample takes priority over a lock completing in the same cycle
    always_comb begin
        nextState = state;
        loadRev   = 1'b0;
        case (state)
            SETTLE: begin
                if (!ReSample && stable) begin
                    nextState = LOCK;
                    loadRev   = 1'b1;
                end
            end
            LOCK: begin
                if (ReSample)
                    nextState = SETTLE;
            end
            default: nextState = SETTLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            Revision <= '0;
        else if (loadRev)
            Revision <= sync;
    end

    assign RevisionValid = (state == LOCK);

    always_comb begin
        revField = '0;
        if (RevisionValid)
            revField[REV_WIDTH-1:0] = Revision;
    end

    always_comb begin
        rdNext = '0;
        case (apb.PADDR)
            SSP_PERIPHID0: rdNext = PART_NUM[7:0];
            SSP_PERIPHID1: rdNext = {DESIGNER[3:0], PART_NUM[11:8]};
            SSP_PERIPHID2: rdNext = {revField, DESIGNER[7:4]};
            SSP_PERIPHID3: rdNext = CONFIG;
            SSP_PCELLID0:  rdNext = SSP_PCELLID0_VAL;
            SSP_PCELLID1:  rdNext = SSP_PCELLID1_VAL;
            SSP_PCELLID2:  rdNext = SSP_PCELLID2_VAL;
            SSP_PCELLID3:  rdNext = SSP_PCELLID3_VAL;
            default:       rdNext = '0;
        endcase
    end

    assign setup = apb.PSEL && !apb.PENABLE && !apb.PWRITE;

    // Loaded during setup so data is ready in the zero-wait access phase
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rdByte <= '0;
            idSelQ <= 1'b0;
        end else if (setup) begin
            rdByte <= rdNext;
            idSelQ <= isIdAddr(apb.PADDR);
        end else begin
            rdByte <= '0;
            idSelQ <= 1'b0;
        end
    end

    assign apb.PRDATA = {24'h0, rdByte};
    assign apb.IdSel  = idSelQ;

endmodule

// File: tb/tb_ssp_rev_id_regs.sv
// Directed bench for the SSP revision/ID register block: table of ID reads plus lock sequences.
module tb_ssp_rev_id_regs;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic [3:0] TieOff1, TieOff2;
    logic       ReSample;
    logic [3:0] Revision;
    logic       RevisionValid;

    int testsRun  = 0;
    int failCount = 0;

    ssp_rev_id_regs_if apb ();

    ssp_rev_id_regs #(
        .REV_WIDTH     (4),
        .PART_NUM      (12'h022),
        .DESIGNER      (8'h41),
        .CONFIG        (8'h00),
        .SETTLE_CYCLES (8)
    ) dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .apb           (apb),
        .TieOff1       (TieOff1),
        .TieOff2       (TieOff2),
        .ReSample      (ReSample),
        .Revision      (Revision),
        .RevisionValid (RevisionValid)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        string      name;
        logic [9:0] addr;
        logic [7:0] expData;
        logic       expSel;
    } readVec_t;

    readVec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        while (RevisionValid !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic apbRead(input logic [9:0] addr, output logic [31:0] data, output logic sel);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = addr;
        tick();
        apb.PENABLE = 1'b1;
        data = apb.PRDATA;
        sel  = apb.IdSel;
        tick();
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic resetPulse();
        PRESETn = 1'b0;
        tick();
        tick();
        PRESETn = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        sel;
        int          cyc;
        logic        sawValid;

        vecs[0] = '{"PeriphID0", 10'h3F8, 8'h22, 1'b1};
        vecs[1] = '{"PeriphID1", 10'h3F9, 8'h10, 1'b1};
        vecs[2] = '{"PeriphID2", 10'h3FA, 8'h34, 1'b1};
        vecs[3] = '{"PeriphID3", 10'h3FB, 8'h00, 1'b1};
        vecs[4] = '{"PCellID0",  10'h3FC, 8'h0D, 1'b1};
        vecs[5] = '{"PCellID1",  10'h3FD, 8'hF0, 1'b1};
        vecs[6] = '{"PCellID2",  10'h3FE, 8'h05, 1'b1};
        vecs[7] = '{"PCellID3",  10'h3FF, 8'hB1, 1'b1};
        vecs[8] = '{"Addr000",   10'h000, 8'h00, 1'b0};

        PRESETn     = 1'b0;
        TieOff1     = 4'hF;
        TieOff2     = 4'h3;
        ReSample    = 1'b0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        tick();
        tick();
        check("reset_prdata", apb.PRDATA, 32'h0);
        check("reset_idsel", {31'h0, apb.IdSel}, 32'h0);
        check("reset_revision", {28'h0, Revision}, 32'h0);
        check("reset_valid", {31'h0, RevisionValid}, 32'h0);

        // Basic lock latency from reset release
        PRESETn = 1'b1;
        waitValid(cyc);
        check("lock_latency", cyc, 10);
        check("lock_revision", {28'h0, Revision}, 32'h3);

        foreach (vecs[i]) begin
            apbRead(vecs[i].addr, rd, sel);
            check({vecs[i].name, "_data"}, rd, {24'h0, vecs[i].expData});
            check({vecs[i].name, "_idsel"}, {31'h0, sel}, {31'h0, vecs[i].expSel});
            check({vecs[i].name, "_idle"}, apb.PRDATA, 32'h0);
        end

        // Writes are ignored and return zero
        apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = 10'h3FA;
        tick();
        check("write_prdata", apb.PRDATA, 32'h0);
        check("write_idsel", {31'h0, apb.IdSel}, 32'h0);
        apb.PENABLE = 1'b1;
        tick();
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        check("write_revision", {28'h0, Revision}, 32'h3);
        apbRead(10'h3FA, rd, sel);
        check("write_readback", rd, 32'h34);

        // Strap change in LOCK is ignored until ReSample
        TieOff2 = 4'h5;
        repeat (12) tick();
        check("lock_hold_rev", {28'h0, Revision}, 32'h3);
        check("lock_hold_valid", {31'h0, RevisionValid}, 32'h1);
        ReSample = 1'b1;
        tick();
        ReSample = 1'b0;
        check("resample_drop", {31'h0, RevisionValid}, 32'h0);
        apbRead(10'h3FA, rd, sel);
        check("resample_fe8_settling", rd, 32'h04);
        waitValid(cyc);
        check("relock_valid", {31'h0, RevisionValid}, 32'h1);
        check("relock_revision", {28'h0, Revision}, 32'h5);
        apbRead(10'h3FA, rd, sel);
        check("relock_fe8", rd, 32'h54);

        // Toggling strap prevents lock; lock 10 cycles after last change
        TieOff2 = 4'h3;
        resetPulse();
        sawValid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            repeat (5) begin
                tick();
                if (RevisionValid) sawValid = 1'b1;
            end
            TieOff2 = TieOff2 ^ 4'h1;
        end
        check("toggle_no_lock", {31'h0, sawValid}, 32'h0);
        waitValid(cyc);
        check("toggle_lock_latency", cyc, 10);
        check("toggle_revision", {28'h0, Revision}, 32'h3);

        // ReSample coincident with lock completion wins
        resetPulse();
        repeat (9) tick();
        check("coinc_prelock", {31'h0, RevisionValid}, 32'h0);
        ReSample = 1'b1;
        tick();
        ReSample = 1'b0;
        check("coinc_no_lock", {31'h0, RevisionValid}, 32'h0);
        check("coinc_no_rev", {28'h0, Revision}, 32'h0);
        waitValid(cyc);
        check("coinc_relock_latency", cyc, 8);
        check("coinc_revision", {28'h0, Revision}, 32'h3);

        // FE8 setup read in the lock cycle returns the pre-lock field
        resetPulse();
        repeat (9) tick();
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 10'h3FA;
        tick();
        check("lockread_valid", {31'h0, RevisionValid}, 32'h1);
        check("lockread_data", apb.PRDATA, 32'h04);
        check("lockread_idsel", {31'h0, apb.IdSel}, 32'h1);
        apb.PENABLE = 1'b1;
        tick();
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;

        // Reset during an access phase
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = 10'h3FA;
        tick();
        apb.PENABLE = 1'b1;
        check("access_pre_data", apb.PRDATA, 32'h34);
        #2;
        PRESETn = 1'b0;
        #1;
        check("async_rst_prdata", apb.PRDATA, 32'h0);
        check("async_rst_idsel", {31'h0, apb.IdSel}, 32'h0);
        check("async_rst_revision", {28'h0, Revision}, 32'h0);
        check("async_rst_valid", {31'h0, RevisionValid}, 32'h0);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        tick();
        PRESETn = 1'b1;
        waitValid(cyc);
        check("restart_latency", cyc, 10);

        // Reset mid-settle restarts the window
        resetPulse();
        repeat (5) tick();
        #2;
        PRESETn = 1'b0;
        #1;
        check("midsettle_valid", {31'h0, RevisionValid}, 32'h0);
        tick();
        PRESETn = 1'b1;
        waitValid(cyc);
        check("midsettle_latency", cyc, 10);
        check("midsettle_revision", {28'h0, Revision}, 32'h3);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
